// File: rtl/aes_block_packer.sv
`default_nettype none
// ============================================================================
// Module      : aes_block_packer
// Description : Packs a byte stream into BLOCK_BYTES plaintext blocks for the
//               AES encryptor; pads the final block of each message.
//               Define AES_PAD_PKCS7_EN for PKCS#7 padding (zero padding otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_block_packer #(
   parameter int BLOCK_BYTES = 16,
   parameter int CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               s_data,
   input  logic                     s_valid,
   input  logic                     s_last,
   output logic                     s_ready,
   output logic [8*BLOCK_BYTES-1:0] m_block,
   output logic                     m_valid,
   output logic                     m_last,
   input  logic                     m_ready,
   output logic [CNT_W-1:0]         blk_count
);

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_PAD  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [7:0] c_bb = 8'(BLOCK_BYTES);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic       r_pend;
   logic [7:0] w_pad;

`ifdef AES_PAD_PKCS7_EN
   assign w_pad = c_bb - r_cnt;
`else
   assign w_pad = 8'h00;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_FILL;
         r_cnt     <= 8'd0;
         r_pend    <= 1'b0;
         s_ready   <= 1'b0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         m_block   <= '0;
         blk_count <= '0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (s_valid && s_ready) begin
                  // Byte k lands in the k-th most significant byte lane.
                  for (int i = 0; i < BLOCK_BYTES; i++) begin
                     if (8'(i) == r_cnt) begin
                        m_block[8*(BLOCK_BYTES-i)-1 -: 8] <= s_data;
                     end
                  end
                  r_cnt <= r_cnt + 8'd1;
                  if (r_cnt == c_bb - 8'd1) begin
                     r_state <= ST_HOLD;
                     s_ready <= 1'b0;
                     m_valid <= 1'b1;
`ifdef AES_PAD_PKCS7_EN
                     r_pend  <= s_last;
`else
                     m_last  <= s_last;
`endif
                  end else if (s_last) begin
                     r_state <= ST_PAD;
                     s_ready <= 1'b0;
                  end
               end else begin
                  s_ready <= 1'b1;
               end
            end

            ST_PAD: begin
               for (int i = 0; i < BLOCK_BYTES; i++) begin
                  if (8'(i) >= r_cnt) begin
                     m_block[8*(BLOCK_BYTES-i)-1 -: 8] <= w_pad;
                  end
               end
               m_last  <= 1'b1;
               m_valid <= 1'b1;
               r_state <= ST_HOLD;
            end

            ST_HOLD: begin
               if (m_valid && m_ready) begin
                  blk_count <= blk_count + CNT_W'(1);
                  m_valid   <= 1'b0;
                  r_cnt     <= 8'd0;
                  if (r_pend) begin
                     // Aligned message: follow with a whole block of padding.
                     m_block <= {BLOCK_BYTES{c_bb}};
                     r_pend  <= 1'b0;
                     m_last  <= 1'b1;
                  end else begin
                     m_last  <= 1'b0;
                     r_state <= ST_FILL;
                     s_ready <= 1'b1;
                  end
               end else if (!m_valid) begin
                  m_valid <= 1'b1;
               end
            end

            default: begin
               r_state <= ST_FILL;
               s_ready <= 1'b0;
               m_valid <= 1'b0;
               m_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
